// File: rtl/scope_capture_ram.sv
// rtl/scope_capture_ram.sv - multi-channel circular capture buffer with pre/post trigger sequencing
module scope_capture_ram #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int CHANNELS     = 15,
  parameter int ADDR_WIDTH   = 8,
  parameter int PRETRIG      = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             arm,
  input  logic                             samp_valid,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] samp_data,
  input  logic                             trig,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [CHANNELS*SAMPLE_WIDTH-1:0] rd_data,
  output logic                             rd_valid,
  output logic                             busy,
  output logic                             done
);

  localparam int W     = CHANNELS * SAMPLE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PRE_CNT   = ADDR_WIDTH'(PRETRIG);
  localparam logic [ADDR_WIDTH-1:0] PRE_LAST  = ADDR_WIDTH'(PRETRIG - 1);
  localparam logic [ADDR_WIDTH-1:0] POST_INIT = ADDR_WIDTH'(DEPTH - PRETRIG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]          mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] fill;
  logic [ADDR_WIDTH-1:0] post;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  we;
  logic                  re;
  logic                  load_trig;

  // Single shared RAM address: readout owns it in DONE, the writer elsewhere.
  assign ram_addr = (state == S_DONE) ? (trig_addr - PRE_CNT + rd_addr) : wr_ptr;

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    re        = 1'b0;
    load_trig = 1'b0;
    if (reset) begin
      state_nxt = S_IDLE;
    end else if (arm) begin
      state_nxt = (PRETRIG == 0) ? S_WAIT : S_PRE;
    end else begin
      case (state)
        S_PRE: begin
          if (samp_valid) begin
            we = 1'b1;
            if (fill == PRE_LAST) state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (samp_valid) begin
            we = 1'b1;
            if (trig) begin
              load_trig = 1'b1;
              state_nxt = (POST_INIT == '0) ? S_DONE : S_POST;
            end
          end
        end
        S_POST: begin
          if (samp_valid) begin
            we = 1'b1;
            if (post == ADDR_WIDTH'(1)) state_nxt = S_DONE;
          end
        end
        S_DONE: re = rd_en;
        default: ;
      endcase
    end
  end

  assign busy = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      fill      <= '0;
      post      <= '0;
      trig_addr <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= re;
      if (arm) begin
        wr_ptr <= '0;
        fill   <= '0;
      end else if (we) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        if (state == S_PRE) fill <= fill + ADDR_WIDTH'(1);
        if (state == S_POST) post <= post - ADDR_WIDTH'(1);
      end
      if (load_trig) begin
        trig_addr <= wr_ptr;
        post      <= POST_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[ram_addr] <= samp_data;
  end

  // rd_data only changes on an accepted read so it holds between reads.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else if (re) rd_data <= mem[ram_addr];
  end

endmodule

// File: doc/scope_capture_ram.md
Name: scope_capture_ram

Overview:
- Parametrised multi-channel capture buffer for the oscilloscope datapath, built on an inferred single-port block RAM.
- Samples CHANNELS x SAMPLE_WIDTH words into a circular buffer while armed. It holds PRETRIG samples of history, freezes after the trigger plus post-trigger samples, then serves trigger-aligned readout to the display path.
- Replaces the fixed-geometry wide single-port RAM with geometry set by parameters and an integrated capture/trigger sequencer.

Parameters:
- SAMPLE_WIDTH, 8, bits per channel sample.
- CHANNELS, 15, channels packed per RAM word; word width W = CHANNELS*SAMPLE_WIDTH.
- ADDR_WIDTH, 8, DEPTH = 2**ADDR_WIDTH words.
- PRETRIG, 64, samples retained before the trigger sample. Legal range is 0..DEPTH-1; values outside it are illegal.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- arm  input  1  single-cycle pulse that starts or restarts a capture.
- samp_valid  input  1  samp_data and trig are valid this cycle.
- samp_data  input  W  packed sample; channel k occupies bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- trig  input  1  trigger qualifier; only sampled when samp_valid=1.
- rd_en  input  1  read request; honoured only in DONE.
- rd_addr  input  ADDR_WIDTH  read index relative to the capture start; index PRETRIG is the trigger sample.
- rd_data  output  W  read word.
- rd_valid  output  1  rd_data valid.
- busy  output  1  high in PRE, WAIT and POST.
- done  output  1  high in DONE.

Behaviour:
- Reset (synchronous, active-high):
  - Go to IDLE; wr_ptr, fill/post counters and trig_addr clear to 0.
  - rd_data=0, rd_valid=0, busy=0, done=0.
  - RAM contents are not cleared.
  - A reset mid-capture abandons the capture; done stays 0 until a new capture completes.
- RAM: single port, one shared address.
  - Writes occur only in PRE, WAIT and POST, on samp_valid cycles.
  - Reads occur only in DONE.
  - Read latency is 1 cycle, registered.
- IDLE: samples and trig are ignored. arm -> wr_ptr=0, fill=0; go to PRE, or to WAIT if PRETRIG=0.
- PRE:
  - Each samp_valid writes samp_data at wr_ptr; wr_ptr increments mod DEPTH and fill increments.
  - trig is ignored in PRE.
  - When the PRETRIG-th sample is written -> WAIT, effective next cycle.
- WAIT:
  - Each samp_valid writes and advances wr_ptr, wrapping freely.
  - samp_valid&trig: that sample is written, trig_addr <= wr_ptr, post = DEPTH-PRETRIG-1.
  - If post=0 -> DONE; otherwise -> POST.
- POST:
  - Each samp_valid writes, advances wr_ptr and decrements post.
  - The write that brings post to 0 -> DONE; done rises the following cycle.
  - trig is ignored in POST.
- DONE:
  - start = (trig_addr - PRETRIG) mod DEPTH.
  - rd_en at cycle t: RAM address = (start + rd_addr) mod DEPTH; rd_data is updated and rd_valid=1 at t+1.
  - rd_valid is 0 in any cycle following no accepted read; rd_data holds its last value.
  - Back-to-back reads give one word per cycle.
- rd_en outside DONE is ignored: no RAM access, and rd_valid stays 0.
- arm in any non-IDLE state aborts and restarts: wr_ptr=0, fill=0, done falls, go to PRE (or WAIT if PRETRIG=0).
- arm together with rd_en in DONE: arm wins; the read is dropped and rd_valid=0 next cycle.
- arm together with samp_valid in the same cycle: the sample is not written; capture starts with the next samp_valid.
- Buffer result: the buffer holds exactly PRETRIG samples before the trigger sample, the trigger sample, and DEPTH-PRETRIG-1 samples after it.

Test Plan:
Common setup: ADDR_WIDTH=4 (DEPTH=16), PRETRIG=4, CHANNELS=2, SAMPLE_WIDTH=8; sample n = {n,n}.
- Reset: hold reset 2 cycles with rd_en=1 -> rd_valid=0, rd_data=0, busy=0, done=0.
- Basic capture:
  - Stimulus: arm, then samples 0..21 on consecutive cycles, trig with sample 10.
  - Required: done rises the cycle after sample 21 is written; reading rd_addr 0..15 returns 6..21; rd_addr 4 returns 10; each rd_valid appears 1 cycle after its rd_en.
- Early trigger ignored: trig with samples 1, 2 (in PRE) and 7 -> readout 3..18.
- Trigger qualified only with samp_valid:
  - Stimulus: samp_valid every 3rd cycle; trig held high on non-valid cycles before sample 9; trig with sample 9.
  - Required: readout 5..20; samples arriving after done are not written.
- Wrap-around: trig with sample 40 -> start=4; rd_addr 0 returns 36; rd_addr 15 returns 51.
- Abort and re-arm:
  - Stimulus: arm during POST, then samples 100..121 with trig at 110.
  - Required: done drops immediately; readout 106..121.
  - Stimulus: reset mid-WAIT. Required: done stays 0, and rd_en gives no rd_valid.
